// File: rtl/full_err_mem_arb_pkg.sv
// Shared types for the memory arbiter and the memory wrappers it talks to:
// default widths, the memory command struct and the FSM state encoding.
package full_err_mem_arb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 6;

    // One memory command per cycle; wr_en and rd_en are never both set.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic                  wr_en;
        logic                  rd_en;
    } mem_cmd_t;

    // INIT zero-fills the memory, RUN serves the two requesters.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Round-robin pointer encoding: which requester wins a tie.
    localparam logic PTR_A = 1'b0;
    localparam logic PTR_B = 1'b1;

endpackage

// File: rtl/full_err_rr_arb2.sv
// Two-way round-robin decision: requests plus the current priority pointer
// give at most one grant and the pointer value for the next cycle.
module full_err_rr_arb2
    import full_err_mem_arb_pkg::*;
(
    input  logic en_i,
    input  logic a_req_i,
    input  logic b_req_i,
    input  logic ptr_i,
    output logic a_gnt_o,
    output logic b_gnt_o,
    output logic ptr_o
);

    // Single requester always wins and leaves the pointer alone; on a tie the
    // pointer holder wins and the pointer moves to the loser.
    always_comb begin
        a_gnt_o = 1'b0;
        b_gnt_o = 1'b0;
        ptr_o   = ptr_i;
        if (en_i) begin
            if (a_req_i && b_req_i) begin
                if (ptr_i == PTR_A) begin
                    a_gnt_o = 1'b1;
                    ptr_o   = PTR_B;
                end else begin
                    b_gnt_o = 1'b1;
                    ptr_o   = PTR_A;
                end
            end else if (a_req_i) begin
                a_gnt_o = 1'b1;
            end else if (b_req_i) begin
                b_gnt_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/full_err_mem_arb.sv
// Memory front end shared by two requesters. After reset or clear it
// zero-fills the whole memory, then arbitrates A/B accesses round-robin with
// same-cycle grants and a one-cycle read return on a shared rdata bus.
//
// Handshake: an access is accepted in exactly the cycle where req and gnt are
// both high; inputs must be stable in that cycle. A granted read returns its
// data with the requester's rvalid one cycle later, with no backpressure.
module full_err_mem_arb
    import full_err_mem_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              a_req,
    input  logic              a_wr,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_req,
    input  logic              b_wr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_rvalid,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              init_done,
    output mem_cmd_t          mem_cmd,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    output state_e            dbg_state
);

    localparam logic [ADDR_W-1:0] FILL_LAST = {ADDR_W{1'b1}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fill_q, fill_d;
    logic              ptr_q, ptr_d;
    logic              a_rvalid_q, a_rvalid_d;
    logic              b_rvalid_q, b_rvalid_d;

    mem_cmd_t          cmd_d;
    logic [DATA_W-1:0] wr_data_d;

    logic              arb_en;
    logic              arb_a_gnt;
    logic              arb_b_gnt;
    logic              arb_ptr_next;

    // Grants only in RUN, never in a clear cycle, never while in reset.
    assign arb_en = (state_q == ST_RUN) && !clear && !reset;

    full_err_rr_arb2 u_arb (
        .en_i    (arb_en),
        .a_req_i (a_req),
        .b_req_i (b_req),
        .ptr_i   (ptr_q),
        .a_gnt_o (arb_a_gnt),
        .b_gnt_o (arb_b_gnt),
        .ptr_o   (arb_ptr_next)
    );

    // Next-state, fill counter, pointer and memory command selection.
    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        ptr_d      = ptr_q;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        cmd_d      = '0;
        wr_data_d  = '0;
        case (state_q)
            ST_INIT: begin
                if (clear) begin
                    // Restart the fill; no write in the clear cycle itself.
                    fill_d = '0;
                end else begin
                    cmd_d.addr  = fill_q;
                    cmd_d.wr_en = 1'b1;
                    fill_d      = fill_q + 1'b1;
                    // Leave on the last address, not on counter wrap.
                    if (fill_q == FILL_LAST) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (clear) begin
                    state_d = ST_INIT;
                    fill_d  = '0;
                end else begin
                    ptr_d = arb_ptr_next;
                    if (arb_a_gnt) begin
                        cmd_d.addr  = a_addr;
                        cmd_d.wr_en = a_wr;
                        cmd_d.rd_en = !a_wr;
                        wr_data_d   = a_wdata;
                        a_rvalid_d  = !a_wr;
                    end else if (arb_b_gnt) begin
                        cmd_d.addr  = b_addr;
                        cmd_d.wr_en = b_wr;
                        cmd_d.rd_en = !b_wr;
                        wr_data_d   = b_wdata;
                        b_rvalid_d  = !b_wr;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
                fill_d  = '0;
            end
        endcase
    end

    // State register; reset discards the fill position and any pending read.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            fill_q     <= '0;
            ptr_q      <= PTR_A;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            ptr_q      <= ptr_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
        end
    end

    // Outputs are forced quiet while reset is held, even in its first cycle.
    assign a_gnt       = arb_a_gnt;
    assign b_gnt       = arb_b_gnt;
    assign a_rvalid    = a_rvalid_q && !reset;
    assign b_rvalid    = b_rvalid_q && !reset;
    assign rdata       = mem_rd_data;
    assign init_done   = (state_q == ST_RUN) && !reset;
    assign mem_cmd     = reset ? '0 : cmd_d;
    assign mem_wr_data = reset ? '0 : wr_data_d;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_full_err_mem_arb.sv
// Bench for full_err_mem_arb: synchronous memory model, behavioural reference
// model checked every cycle, a vector table, corner-case sequences and a
// randomized phase.
module tb_full_err_mem_arb;
    import full_err_mem_arb_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          a_req = 1'b0, a_wr = 1'b0, b_req = 1'b0, b_wr = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid, init_done;
    logic [DW-1:0] rdata, mem_wr_data;
    logic [DW-1:0] mem_rd_data = '0;
    mem_cmd_t      mem_cmd;
    state_e        dbg_state;

    logic [DW-1:0] ram [DEPTH];

    int checks = 0;
    int errors = 0;

    // clock
    always #5 clk = ~clk;

    full_err_mem_arb #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .a_req       (a_req),
        .a_wr        (a_wr),
        .a_addr      (a_addr),
        .a_wdata     (a_wdata),
        .b_req       (b_req),
        .b_wr        (b_wr),
        .b_addr      (b_addr),
        .b_wdata     (b_wdata),
        .a_gnt       (a_gnt),
        .b_gnt       (b_gnt),
        .a_rvalid    (a_rvalid),
        .b_rvalid    (b_rvalid),
        .rdata       (rdata),
        .init_done   (init_done),
        .mem_cmd     (mem_cmd),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .dbg_state   (dbg_state)
    );

    // synchronous single-port memory, registered read
    always @(posedge clk) begin
        if (mem_cmd.wr_en) ram[mem_cmd.addr] <= mem_wr_data;
        if (mem_cmd.rd_en) mem_rd_data <= ram[mem_cmd.addr];
    end

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit            m_run    = 1'b0;
    int            m_fill   = 0;
    bit            m_ptr_b  = 1'b0;
    bit            m_pa     = 1'b0;
    bit            m_pb     = 1'b0;
    logic [DW-1:0] m_pdata  = '0;
    logic [DW-1:0] m_mem [DEPTH];

    bit            e_a_gnt, e_b_gnt;
    mem_cmd_t      e_cmd;
    logic [DW-1:0] e_wdata;

    function automatic void model_predict();
        e_a_gnt = 1'b0;
        e_b_gnt = 1'b0;
        e_cmd   = '0;
        e_wdata = '0;
        if (reset) return;
        if (!m_run) begin
            if (!clear) begin
                e_cmd.addr  = m_fill[AW-1:0];
                e_cmd.wr_en = 1'b1;
            end
        end else if (!clear) begin
            if (a_req && b_req) begin
                e_a_gnt = !m_ptr_b;
                e_b_gnt = m_ptr_b;
            end else begin
                e_a_gnt = a_req;
                e_b_gnt = b_req;
            end
            if (e_a_gnt) begin
                e_cmd.addr = a_addr; e_cmd.wr_en = a_wr; e_cmd.rd_en = !a_wr; e_wdata = a_wdata;
            end
            if (e_b_gnt) begin
                e_cmd.addr = b_addr; e_cmd.wr_en = b_wr; e_cmd.rd_en = !b_wr; e_wdata = b_wdata;
            end
        end
    endfunction

    task automatic model_check();
        model_predict();
        cmp("m_a_gnt", 64'(a_gnt), 64'(e_a_gnt));
        cmp("m_b_gnt", 64'(b_gnt), 64'(e_b_gnt));
        cmp("m_a_rvalid", 64'(a_rvalid), 64'(!reset && m_pa));
        cmp("m_b_rvalid", 64'(b_rvalid), 64'(!reset && m_pb));
        cmp("m_init_done", 64'(init_done), 64'(!reset && m_run));
        cmp("m_mem_cmd", 64'(mem_cmd), 64'(e_cmd));
        cmp("m_mem_wr_data", 64'(mem_wr_data), 64'(e_wdata));
        if (!reset && (m_pa || m_pb)) cmp("m_rdata", 64'(rdata), 64'(m_pdata));
    endtask

    task automatic model_advance();
        if (reset) begin
            m_run = 1'b0; m_fill = 0; m_ptr_b = 1'b0; m_pa = 1'b0; m_pb = 1'b0;
            return;
        end
        m_pa = e_a_gnt && !a_wr;
        m_pb = e_b_gnt && !b_wr;
        if (m_pa) m_pdata = m_mem[a_addr];
        if (m_pb) m_pdata = m_mem[b_addr];
        if (!m_run) begin
            if (clear) m_fill = 0;
            else begin
                m_mem[m_fill[AW-1:0]] = '0;
                m_fill++;
                if (m_fill == DEPTH) begin m_run = 1'b1; m_fill = 0; end
            end
        end else if (clear) begin
            m_run = 1'b0; m_fill = 0;
        end else begin
            if (e_a_gnt && a_wr) m_mem[a_addr] = a_wdata;
            if (e_b_gnt && b_wr) m_mem[b_addr] = b_wdata;
            if (a_req && b_req) m_ptr_b = e_a_gnt;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic settle();
        #1;
    endtask

    task automatic finish_cycle();
        model_check();
        model_advance();
        @(negedge clk);
    endtask

    task automatic cyc();
        settle();
        finish_cycle();
    endtask

    task automatic drive(input bit ar, input bit aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input bit br, input bit bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        a_req = ar; a_wr = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_wr = bw; b_addr = ba; b_wdata = bd;
    endtask

    task automatic idle();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        clear = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit            a_req, a_wr;
        logic [AW-1:0] a_addr;
        logic [DW-1:0] a_wdata;
        bit            b_req, b_wr;
        logic [AW-1:0] b_addr;
        logic [DW-1:0] b_wdata;
        bit            ea_gnt, eb_gnt, ea_rv, eb_rv;
        logic [DW-1:0] erdata;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(bit ar, bit aw, logic [AW-1:0] aa, logic [DW-1:0] ad,
                                bit br, bit bw, logic [AW-1:0] ba, logic [DW-1:0] bd,
                                bit eag, bit ebg, bit ear, bit ebr, logic [DW-1:0] erd);
        vec_t v;
        v.a_req = ar; v.a_wr = aw; v.a_addr = aa; v.a_wdata = ad;
        v.b_req = br; v.b_wr = bw; v.b_addr = ba; v.b_wdata = bd;
        v.ea_gnt = eag; v.eb_gnt = ebg; v.ea_rv = ear; v.eb_rv = ebr; v.erdata = erd;
        return v;
    endfunction

    initial begin
        // A write / read back
        vq.push_back(mk(1,1,6'd5,32'hDEADBEEF, 0,0,6'd0,32'h0, 1,0,0,0,32'h0));
        vq.push_back(mk(1,0,6'd5,32'h0,        0,0,6'd0,32'h0, 1,0,0,0,32'h0));
        vq.push_back(mk(0,0,6'd0,32'h0,        0,0,6'd0,32'h0, 0,0,1,0,32'hDEADBEEF));
        // both read continuously for 6 cycles: A,B,A,B,A,B
        for (int i = 0; i < 6; i++)
            vq.push_back(mk(1,0,6'd1,32'h0, 1,0,6'd2,32'h0,
                            (i % 2) == 0, (i % 2) == 1, i != 0 && (i % 2) == 1, i != 0 && (i % 2) == 0, 32'h0));
        vq.push_back(mk(0,0,6'd0,32'h0,        0,0,6'd0,32'h0, 0,0,0,1,32'h0));
        // B write alone, then contention with pointer moving
        vq.push_back(mk(0,0,6'd0,32'h0,        1,1,6'd7,32'h12345678, 0,1,0,0,32'h0));
        vq.push_back(mk(1,1,6'd9,32'hCAFEF00D, 1,0,6'd7,32'h0, 1,0,0,0,32'h0));
        vq.push_back(mk(1,0,6'd9,32'h0,        1,0,6'd7,32'h0, 0,1,0,0,32'h0));
        vq.push_back(mk(1,0,6'd9,32'h0,        0,0,6'd0,32'h0, 1,0,0,1,32'h12345678));
        vq.push_back(mk(0,0,6'd0,32'h0,        0,0,6'd0,32'h0, 0,0,1,0,32'hCAFEF00D));
        // A alone 10 cycles, then a tie still goes to A
        for (int i = 0; i < 10; i++)
            vq.push_back(mk(1,0,6'(10 + i),32'h0, 0,0,6'd0,32'h0, 1,0,i != 0,0,32'h0));
        vq.push_back(mk(1,0,6'd5,32'h0,        1,0,6'd7,32'h0, 1,0,1,0,32'h0));
        vq.push_back(mk(0,0,6'd0,32'h0,        0,0,6'd0,32'h0, 0,0,1,0,32'hDEADBEEF));
    end

    // ---------------- test sequence ----------------
    initial begin
        @(negedge clk);
        // reset state
        reset = 1'b1;
        idle();
        for (int i = 0; i < 3; i++) cyc();

        // zero-fill after reset release, with both requesters pushing
        reset = 1'b0;
        drive(1, 0, 6'd3, '0, 1, 0, 6'd4, '0);
        for (int i = 0; i < DEPTH; i++) begin
            settle();
            cmp("fill_wr_en", 64'(mem_cmd.wr_en), 64'(1));
            cmp("fill_addr", 64'(mem_cmd.addr), 64'(i));
            cmp("fill_data", 64'(mem_wr_data), 64'(0));
            cmp("fill_gnt", 64'({a_gnt, b_gnt}), 64'(0));
            finish_cycle();
        end
        idle();
        settle();
        cmp("init_done_after_fill", 64'(init_done), 64'(1));
        finish_cycle();

        // vector table
        foreach (vq[k]) begin
            drive(vq[k].a_req, vq[k].a_wr, vq[k].a_addr, vq[k].a_wdata,
                  vq[k].b_req, vq[k].b_wr, vq[k].b_addr, vq[k].b_wdata);
            settle();
            cmp($sformatf("vec%0d_a_gnt", k), 64'(a_gnt), 64'(vq[k].ea_gnt));
            cmp($sformatf("vec%0d_b_gnt", k), 64'(b_gnt), 64'(vq[k].eb_gnt));
            cmp($sformatf("vec%0d_a_rvalid", k), 64'(a_rvalid), 64'(vq[k].ea_rv));
            cmp($sformatf("vec%0d_b_rvalid", k), 64'(b_rvalid), 64'(vq[k].eb_rv));
            if (vq[k].ea_rv || vq[k].eb_rv)
                cmp($sformatf("vec%0d_rdata", k), 64'(rdata), 64'(vq[k].erdata));
            finish_cycle();
        end
        idle();

        // read of addr 63 by B, clear in the next cycle
        drive(0, 0, '0, '0, 1, 0, 6'd63, '0);
        settle();
        cmp("pre_clear_b_gnt", 64'(b_gnt), 64'(1));
        finish_cycle();
        drive(1, 0, 6'd1, '0, 1, 0, 6'd2, '0);
        clear = 1'b1;
        settle();
        cmp("clear_b_rvalid", 64'(b_rvalid), 64'(1));
        cmp("clear_rdata", 64'(rdata), 64'(0));
        cmp("clear_gnt", 64'({a_gnt, b_gnt}), 64'(0));
        finish_cycle();
        clear = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            settle();
            cmp("refill_gnt", 64'({a_gnt, b_gnt}), 64'(0));
            cmp("refill_init_done", 64'(init_done), 64'(0));
            cmp("refill_addr", 64'(mem_cmd.addr), 64'(i));
            finish_cycle();
        end
        drive(1, 0, 6'd5, '0, 0, 0, '0, '0);
        settle();
        cmp("post_clear_init_done", 64'(init_done), 64'(1));
        cmp("post_clear_a_gnt", 64'(a_gnt), 64'(1));
        finish_cycle();
        idle();
        settle();
        cmp("post_clear_a_rvalid", 64'(a_rvalid), 64'(1));
        cmp("post_clear_rdata", 64'(rdata), 64'(0));
        finish_cycle();

        // reset mid-read: the pending rvalid must be dropped
        drive(1, 0, 6'd5, '0, 0, 0, '0, '0);
        cyc();
        idle();
        reset = 1'b1;
        settle();
        cmp("reset_mid_read_rvalid", 64'(a_rvalid), 64'(0));
        cmp("reset_mem_cmd", 64'(mem_cmd), 64'(0));
        finish_cycle();
        reset = 1'b0;
        settle();
        cmp("after_reset_rvalid", 64'({a_rvalid, b_rvalid}), 64'(0));
        finish_cycle();

        // reset at fill address 30: fill restarts at 0
        for (int i = 1; i < 30; i++) cyc();
        settle();
        cmp("fill_at_30", 64'(mem_cmd.addr), 64'(30));
        reset = 1'b1;
        #1;
        cmp("reset_at_30_cmd", 64'(mem_cmd), 64'(0));
        finish_cycle();
        reset = 1'b0;
        settle();
        cmp("restart_addr", 64'(mem_cmd.addr), 64'(0));
        cmp("restart_wr_en", 64'(mem_cmd.wr_en), 64'(1));
        cmp("restart_rvalid", 64'({a_rvalid, b_rvalid}), 64'(0));
        finish_cycle();
        for (int i = 1; i < DEPTH; i++) cyc();

        // randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 399) == 0);
            clear = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, 6'($urandom_range(0, DEPTH - 1)), $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, 6'($urandom_range(0, DEPTH - 1)), $urandom);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/full_err_mem_arb.md
FULL_ERR_MEM_ARB -- requirements
Module: full_err_mem_arb

Interface
REQ-001 Parameter: DATA_W, 32, memory word width.
REQ-002 Parameter: ADDR_W, 6, memory address width (64 entries).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: clear  input  1  one-cycle pulse; restarts memory zero-fill.
REQ-006 Port: a_req / b_req  input  1  requester A / B access request.
REQ-007 Port: a_wr / b_wr  input  1  1 = write, 0 = read.
REQ-008 Port: a_addr / b_addr  input  ADDR_W  access address.
REQ-009 Port: a_wdata / b_wdata  input  DATA_W  write data.
REQ-010 Port: a_gnt / b_gnt  output  1  request accepted this cycle.
REQ-011 Port: a_rvalid / b_rvalid  output  1  read data valid for that requester.
REQ-012 Port: rdata  output  DATA_W  read data; shared by both requesters and qualified by the rvalid signals.
REQ-013 Port: init_done  output  1  high when zero-fill is complete and grants are enabled.
REQ-014 Port: mem_cmd  output  mem command struct  {addr, wr_en, rd_en} to the memory.
REQ-015 Port: mem_wr_data  output  DATA_W  memory write data.
REQ-016 Port: mem_rd_data  input  DATA_W  memory read data; valid one cycle after rd_en.

Function
REQ-017 The FSM SHALL have two states: INIT and RUN.
REQ-018 In INIT, the block SHALL write zero to addresses 0..63, one per cycle, using an ADDR_W-bit fill counter.
REQ-019 After the write to address 63, the FSM SHALL move to RUN and assert init_done on the next cycle.
REQ-020 In INIT, a_gnt and b_gnt SHALL be 0.
REQ-021 In RUN with no clear, gnt SHALL be combinational in the same cycle as req.
REQ-022 An access is accepted exactly when req and gnt are both high in the same cycle.
REQ-023 In RUN, at most one grant SHALL be asserted per cycle.
REQ-024 With a single requester, that requester SHALL be granted every cycle.
REQ-025 With both requesters, the one holding the priority pointer SHALL win.
REQ-026 After a cycle in which both requested, the pointer SHALL move to the loser.
REQ-027 A single-requester grant SHALL NOT move the pointer.
REQ-028 A granted access SHALL drive mem_cmd and mem_wr_data in the same cycle as the grant: addr from the winner, wr_en = winner's wr, rd_en = not wr.
REQ-029 A granted read SHALL assert the winner's rvalid exactly one cycle later, with rdata = mem_rd_data.
REQ-030 Read latency SHALL be 1 cycle, and back-to-back reads SHALL be supported at full throughput.
REQ-031 A granted write SHALL produce no rvalid.
REQ-032 A read granted in the cycle after a write to the same address SHALL return the new data, relying on memory write-before-read.
REQ-033 When no access is granted, mem_cmd wr_en and rd_en SHALL be 0.
REQ-034 Clear in RUN: no grant in the clear cycle; the FSM enters INIT the next cycle with the fill counter at 0 and init_done low.
REQ-035 A read granted in the cycle before clear SHALL still return its rvalid.
REQ-036 Clear in INIT SHALL restart the fill counter at 0.
REQ-037 The fill counter SHALL be a plain ADDR_W-bit counter; INIT exits on count 63, not on wrap.

Reset
REQ-038 While reset is high: FSM = INIT, fill counter = 0, pointer = A, init_done = 0, all rvalid = 0, gnt = 0, mem_cmd = 0, mem_wr_data = 0.
REQ-039 Zero-fill SHALL begin on the first cycle after reset deasserts.
REQ-040 Reset asserted mid-fill or mid-read SHALL discard all in-flight state, and no rvalid SHALL follow.

Structure
REQ-041 The mem command struct typedef (addr/wr_en/rd_en for 32x6) and the DATA_W/ADDR_W defaults SHALL reside in the shared types package used by the memory wrappers.
REQ-042 The two-way round-robin decision (requests + pointer -> grants, next pointer) SHALL be one sub-module, full_err_rr_arb2.

Verification
REQ-043 Reset release, no requests: mem_cmd.wr_en = 1 for 64 consecutive cycles with addr 0..63 and data 0, then init_done = 1; a_gnt/b_gnt stay 0 throughout.
REQ-044 After init, A writes 0xDEADBEEF to addr 5, then A reads addr 5: a_gnt = 1 both cycles, a_rvalid = 1 one cycle after the read, rdata = 0xDEADBEEF, b_rvalid = 0.
REQ-045 A and B both read continuously for 6 cycles after reset: grants alternate A,B,A,B,A,B, and each rvalid follows its grant by exactly 1 cycle.
REQ-046 B reads addr 63 while clear pulses in the next cycle: b_rvalid is still delivered; no grants during the clear cycle or the following 64-cycle fill; a read of addr 5 after init_done returns 0.
REQ-047 Reset pulsed at fill address 30: fill restarts at address 0 after release, and no rvalid appears.
REQ-048 A requests alone every cycle for 10 cycles: a_gnt = 1 every cycle; a subsequent simultaneous A+B request grants A (pointer unchanged).
